muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer and HI/LO owner for the pipelined MIPS core; sits beside the E-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and models the architectural latency with a counter FSM.
- Tells the hazard unit when a D-stage HI/LO user must stall.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  E-stage op valid this cycle
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
- a  in  32  rs operand
- b  in  32  rt operand
- use_md_d  in  1  D-stage instruction is an md op, MFHI or MFLO
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  operation in flight
- stall  out  1  stall request to hazard unit
- drop  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, drop=0, state=IDLE, counter=0, temp regs=0.
- FSM states: IDLE and BUSY.
- IDLE, start & op in {MULT..DIVU}:
  - Result computed combinationally from a and b, latched into tmp_hi/tmp_lo at the edge.
  - counter loaded with MULT_CYCLES or DIV_CYCLES. Go to BUSY.
- IDLE, start & MTHI/MTLO: hi (or lo) <= a at that edge; stay IDLE; busy stays 0.
- IDLE, start & reserved op: ignored, no drop pulse.
- BUSY: counter decrements each edge. At the edge where counter==1: hi<=tmp_hi, lo<=tmp_lo, state->IDLE.
- busy=1 for exactly N consecutive cycles (N = MULT_CYCLES or DIV_CYCLES), starting the cycle after the start edge. New hi/lo visible the cycle busy falls.
- start while BUSY (any op incl. MT*): ignored, state unchanged; drop=1 for the following cycle. The hazard unit is expected to prevent this; drop exists for assertion checking.
- stall = use_md_d & (busy | (start & op in {MULT..DIVU})). Combinational; the MT* start term is excluded because MT* completes in one edge.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor 0 (DIV or DIVU): full busy latency still applies, hi/lo left unchanged at commit.
- hi/lo change only at reset, an MT* edge, or a commit edge.
- reset asserted mid-BUSY: aborts immediately; hi/lo cleared; no commit.

Optional Feature:
- Macro MD_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit, placed after drop), driven by the exception/flush logic.
  - cancel=1 in BUSY: state->IDLE at that edge, no commit, hi/lo keep pre-op values, busy=0 the next cycle.
  - cancel=1 in the same cycle as an IDLE start: the start is suppressed entirely (no MT* write, no BUSY entry).
  - cancel in IDLE without start: no effect.
  - cancel has priority over commit on the counter==1 edge.
- Undefined: port absent; every started op always commits.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE (-2), b=0x00000003 at edge T -> busy high T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 with prior hi=lo=0x12345678 -> after 10 cycles both still 0x12345678.
- MTHI a=0xCAFEBABE while idle -> hi=0xCAFEBABE next cycle, busy never rises. MTLO issued during BUSY -> lo unchanged, drop pulses one cycle.
- use_md_d=1 held: stall=1 in start cycle and all 5 MULT busy cycles, 0 on commit cycle. use_md_d=0 -> stall=0 throughout.
- Reset asserted at busy cycle 3 of DIV -> outputs zero asynchronously, no later commit. With MD_CANCEL_EN: cancel at busy cycle 4 of MULT -> hi/lo retain old values, busy=0 next cycle.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//
// Multi-cycle multiply/divide sequencer and owner of the architectural HI/LO
// registers for the pipelined MIPS core. It sits beside the E-stage ALU.
// MULT/MULTU/DIV/DIVU results are computed combinationally when the op is
// accepted. They are parked in temporary registers, and a counter FSM holds
// them back for the architectural latency before they commit to HI/LO.
// MTHI/MTLO write HI/LO on the accepting edge.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset, clears all state
//   start     in   E-stage op valid this cycle
//   op[2:0]   in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                  100 MTHI, 101 MTLO, 11x reserved (ignored)
//   a[31:0]   in   rs operand
//   b[31:0]   in   rt operand
//   use_md_d  in   D-stage instruction is an md op, MFHI or MFLO
//   hi[31:0]  out  architectural HI
//   lo[31:0]  out  architectural LO
//   busy      out  multiply/divide in flight
//   stall     out  stall request to the hazard unit
//   drop      out  one-cycle pulse: a start arrived while busy and was ignored
//   cancel    in   (only with MD_CANCEL_EN) flush request from the exception
//                  logic. It aborts an op in flight, or suppresses a start.
//
// Optional feature macro: MD_CANCEL_EN
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        use_md_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        drop
`ifdef MD_CANCEL_EN
  ,
  input  logic        cancel
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] tmp_hi_q, tmp_hi_d;
  logic [31:0] tmp_lo_q, tmp_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        drop_q, drop_d;
  logic        skip_q, skip_d;

  logic        cancel_w;

`ifdef MD_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  // Datapath. Both operands are widened to 64 bits before multiplying, so
  // the product is exact. The divisor is replaced by 1 when it is zero. That
  // keeps the dividers well defined. The zero case never commits anyway.
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic signed [31:0] a_s, b_safe_s, quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;
  logic               div_zero, div_ovf;

  assign a_sx     = {{32{a[31]}}, a};
  assign b_sx     = {{32{b[31]}}, b};
  assign prod_s   = a_sx * b_sx;
  assign prod_u   = {32'd0, a} * {32'd0, b};

  assign div_zero = (b == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b;
  assign a_s      = a;
  assign b_safe_s = b_safe;

  // The most-negative / -1 case overflows the signed quotient. It is pinned
  // to quotient 0x80000000 with remainder 0.
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    quo_s = 32'sd0;
    rem_s = 32'sd0;
    if (div_ovf) begin
      quo_s = 32'sh8000_0000;
      rem_s = 32'sd0;
    end else begin
      quo_s = a_s / b_safe_s;
      rem_s = a_s % b_safe_s;
    end
  end

  assign quo_u = a / b_safe;
  assign rem_u = a % b_safe;

  // State and architectural registers. Reset clears everything at once,
  // including an op in flight, so a reset during BUSY never commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      drop_q   <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      drop_q   <= drop_d;
      skip_q   <= skip_d;
    end
  end

  // Next-state logic.
  // In IDLE, an md op captures its result and loads the latency counter.
  // MT* writes HI/LO directly. In BUSY, the counter runs down and the result
  // commits on the edge where it reads 1. A divide by zero sets skip, which
  // keeps the full latency but leaves HI/LO untouched. Any start seen while
  // busy is discarded, and drop flags it on the next cycle. Cancel beats
  // both commit and start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    skip_d   = skip_q;
    drop_d   = start && (state_q == BUSY);

    unique case (state_q)
      IDLE: begin
        if (start && !cancel_w) begin
          case (op)
            OP_MULT: begin
              tmp_hi_d = prod_s[63:32];
              tmp_lo_d = prod_s[31:0];
              skip_d   = 1'b0;
              cnt_d    = MULT_CNT;
              state_d  = BUSY;
            end
            OP_MULTU: begin
              tmp_hi_d = prod_u[63:32];
              tmp_lo_d = prod_u[31:0];
              skip_d   = 1'b0;
              cnt_d    = MULT_CNT;
              state_d  = BUSY;
            end
            OP_DIV: begin
              tmp_hi_d = rem_s;
              tmp_lo_d = quo_s;
              skip_d   = div_zero;
              cnt_d    = DIV_CNT;
              state_d  = BUSY;
            end
            OP_DIVU: begin
              tmp_hi_d = rem_u;
              tmp_lo_d = quo_u;
              skip_d   = div_zero;
              cnt_d    = DIV_CNT;
              state_d  = BUSY;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cancel_w) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          if (!skip_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // An MT* start does not raise stall, because it completes on its own edge
  // and a following MFHI/MFLO sees the new value in time.
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == BUSY);
  assign drop  = drop_q;
  assign stall = use_md_d && (busy || (start && !op[2]));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
//
// Self-checking bench for muldiv_ctrl. A behavioural model tracks HI/LO, the
// remaining busy cycles and any pending result using plain 64-bit arithmetic.
// The outputs are compared against it on every cycle. Directed sequences pin
// the model to hand-computed values. Randomized traffic then covers the rest.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        tb_reset;
  logic        tb_start;
  logic [2:0]  tb_op;
  logic [31:0] tb_a;
  logic [31:0] tb_b;
  logic        tb_use;
  logic        tb_cancel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        drop;

  int n_vec;
  int n_bad;

  // Model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_rem;
  logic        m_commit;
  logic        m_drop;

  muldiv_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk     (clk),
    .reset   (tb_reset),
    .start   (tb_start),
    .op      (tb_op),
    .a       (tb_a),
    .b       (tb_b),
    .use_md_d(tb_use),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall   (stall),
    .drop    (drop)
`ifdef MD_CANCEL_EN
    ,
    .cancel  (tb_cancel)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    m_phi    = 32'd0;
    m_plo    = 32'd0;
    m_rem    = 0;
    m_commit = 1'b0;
    m_drop   = 1'b0;
  endtask

  // Advance the model across one rising edge, using the inputs held during
  // the cycle that just ended.
  task automatic modelStep();
    longint      sq, sr;
    logic [63:0] full;
    if (m_rem > 0) begin
      m_drop = tb_start;
      if (tb_cancel) begin
        m_rem = 0;
      end else begin
        m_rem--;
        if (m_rem == 0 && m_commit) begin
          m_hi = m_phi;
          m_lo = m_plo;
        end
      end
    end else begin
      m_drop = 1'b0;
      if (tb_start && !tb_cancel) begin
        case (tb_op)
          3'd0: begin
            full     = 64'(longint'($signed(tb_a)) * longint'($signed(tb_b)));
            m_phi    = full[63:32];
            m_plo    = full[31:0];
            m_commit = 1'b1;
            m_rem    = MULT_N;
          end
          3'd1: begin
            full     = {32'd0, tb_a} * {32'd0, tb_b};
            m_phi    = full[63:32];
            m_plo    = full[31:0];
            m_commit = 1'b1;
            m_rem    = MULT_N;
          end
          3'd2: begin
            m_commit = (tb_b != 32'd0);
            if (m_commit) begin
              sq    = longint'($signed(tb_a)) / longint'($signed(tb_b));
              sr    = longint'($signed(tb_a)) % longint'($signed(tb_b));
              m_plo = sq[31:0];
              m_phi = sr[31:0];
            end
            m_rem = DIV_N;
          end
          3'd3: begin
            m_commit = (tb_b != 32'd0);
            if (m_commit) begin
              m_plo = tb_a / tb_b;
              m_phi = tb_a % tb_b;
            end
            m_rem = DIV_N;
          end
          3'd4: m_hi = tb_a;
          3'd5: m_lo = tb_a;
          default: ;
        endcase
      end
    end
  endtask

  // Compare all outputs against the model. This runs mid-cycle, so stall is
  // evaluated with the inputs currently driven.
  task automatic checkOutput();
    logic exp_stall;
    exp_stall = tb_use && ((m_rem > 0) || (tb_start && (tb_op < 3'd4)));
    checkVal("hi",    hi,             m_hi);
    checkVal("lo",    lo,             m_lo);
    checkVal("busy",  {31'd0, busy},  {31'd0, (m_rem > 0)});
    checkVal("drop",  {31'd0, drop},  {31'd0, m_drop});
    checkVal("stall", {31'd0, stall}, {31'd0, exp_stall});
  endtask

  // Drive one cycle: set inputs just after an edge, check at the falling
  // edge, then step the model at the next rising edge.
  task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [31:0] av,
                               input logic [31:0] bv, input logic u, input logic c);
    tb_start  = s;
    tb_op     = o;
    tb_a      = av;
    tb_b      = bv;
    tb_use    = u;
    tb_cancel = c;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle(input int n, input logic u);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, u, 1'b0);
  endtask

  function automatic logic [31:0] randOperand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'(int'($urandom_range(0, 20)));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    tb_reset  = 1'b1;
    tb_start  = 1'b0;
    tb_op     = 3'd0;
    tb_a      = 32'd0;
    tb_b      = 32'd0;
    tb_use    = 1'b0;
    tb_cancel = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    tb_reset = 1'b0;

    // MULT -2 * 3, with use_md_d held high to exercise stall
    applyStimulus(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    idle(MULT_N, 1'b1);
    checkVal("mult_hi", hi, 32'hFFFF_FFFF);
    checkVal("mult_lo", lo, 32'hFFFF_FFFA);
    checkVal("model_mult_hi", m_hi, 32'hFFFF_FFFF);
    checkVal("model_mult_lo", m_lo, 32'hFFFF_FFFA);
    idle(1, 1'b1);

    // MULTU 0xFFFFFFFF^2
    applyStimulus(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(MULT_N, 1'b0);
    checkVal("multu_hi", hi, 32'hFFFF_FFFE);
    checkVal("multu_lo", lo, 32'h0000_0001);

    // DIV -7 / 2
    applyStimulus(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(DIV_N, 1'b0);
    checkVal("div_lo", lo, 32'hFFFF_FFFD);
    checkVal("div_hi", hi, 32'hFFFF_FFFF);
    checkVal("model_div_lo", m_lo, 32'hFFFF_FFFD);

    // DIV overflow case
    applyStimulus(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(DIV_N, 1'b0);
    checkVal("divovf_lo", lo, 32'h8000_0000);
    checkVal("divovf_hi", hi, 32'h0000_0000);

    // DIVU by zero leaves HI/LO untouched
    applyStimulus(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    idle(DIV_N, 1'b0);
    checkVal("divu0_hi", hi, 32'h1234_5678);
    checkVal("divu0_lo", lo, 32'h1234_5678);

    // MTHI while idle
    applyStimulus(1'b1, 3'd4, 32'hCAFE_BABE, 32'd0, 1'b1, 1'b0);
    checkVal("mthi_hi", hi, 32'hCAFE_BABE);
    checkVal("mthi_busy", {31'd0, busy}, 32'd0);
    idle(1, 1'b0);

    // MTLO during BUSY is dropped
    applyStimulus(1'b1, 3'd0, 32'd6, 32'd7, 1'b0, 1'b0);
    idle(1, 1'b0);
    applyStimulus(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    checkVal("drop_pulse", {31'd0, drop}, 32'd1);
    idle(MULT_N, 1'b0);
    checkVal("drop_lo", lo, 32'd42);

    // Reset during busy cycle 3 of DIV
    applyStimulus(1'b1, 3'd2, 32'd100, 32'd3, 1'b0, 1'b0);
    idle(2, 1'b0);
    tb_reset = 1'b1;
    #1;
    checkVal("rst_hi", hi, 32'd0);
    checkVal("rst_lo", lo, 32'd0);
    checkVal("rst_busy", {31'd0, busy}, 32'd0);
    modelReset();
    @(negedge clk);
    tb_reset = 1'b0;
    @(posedge clk);
    modelStep();
    #1;
    idle(DIV_N + 2, 1'b0);
    checkVal("rst_nocommit_lo", lo, 32'd0);

`ifdef MD_CANCEL_EN
    // Cancel at busy cycle 4 of MULT
    applyStimulus(1'b1, 3'd4, 32'h1111_1111, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd5, 32'h2222_2222, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 32'd9, 32'd9, 1'b0, 1'b0);
    idle(3, 1'b0);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    checkVal("cancel_busy", {31'd0, busy}, 32'd0);
    checkVal("cancel_hi", hi, 32'h1111_1111);
    checkVal("cancel_lo", lo, 32'h2222_2222);
    idle(MULT_N, 1'b0);
    checkVal("cancel_nocommit", lo, 32'h2222_2222);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic c;
      c = 1'b0;
`ifdef MD_CANCEL_EN
      c = ($urandom_range(0, 15) == 0);
`endif
      applyStimulus(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                    randOperand(), randOperand(), 1'($urandom_range(0, 1)), c);
    end
    idle(DIV_N + 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
